// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit: per-operand Execute/Decode forwarding selects,
// a multi-cycle load-use stall, the registered post-stall bubble and a saturating event counter.
module fwd_hazard_unit #(
  parameter int RB       = 5,
  parameter int NSRC     = 2,
  parameter int LOAD_LAT = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NSRC-1:0]      ifid_need,
  input  logic [NSRC*RB-1:0]   ifid_rs,
  input  logic [NSRC-1:0]      idex_need,
  input  logic [NSRC*RB-1:0]   idex_rs,
  input  logic                 exmem_we,
  input  logic                 exmem_is_load,
  input  logic [RB-1:0]        exmem_rdst,
  input  logic                 memwb_we,
  input  logic [RB-1:0]        memwb_rdst,
  output logic [NSRC*2-1:0]    op_exs,
  output logic [NSRC-1:0]      op_ids,
  output logic                 stall,
  output logic                 bubble,
  output logic [15:0]          hz_count
);

  typedef enum logic {
    IDLE,
    WAIT
  } state_t;

  localparam logic [3:0] LAT_M1 = 4'(LOAD_LAT - 1);

  state_t          state;
  state_t          state_next;
  logic [3:0]      cnt;
  logic [3:0]      cnt_next;
  logic            bubble_next;
  logic            stall_int;
  logic            count_en;
  logic            hz;
  logic [NSRC-1:0] ld_hit;

  function automatic logic is_zero(input logic [RB-1:0] r);
    return (ZERO_REG != 0) && (r == '0);
  endfunction

  // Per-operand match logic; a hard-wired zero register never matches anything.
  for (genvar i = 0; i < NSRC; i++) begin : g_src
    logic [RB-1:0] ex_rs;
    logic [RB-1:0] id_rs;
    logic          ex_valid;
    logic          id_valid;
    logic          ex_hit;
    logic          wb_hit;

    assign ex_rs    = idex_rs[i*RB +: RB];
    assign id_rs    = ifid_rs[i*RB +: RB];
    assign ex_valid = idex_need[i] && !is_zero(ex_rs);
    assign id_valid = ifid_need[i] && !is_zero(id_rs);

    assign ex_hit    = exmem_we && !exmem_is_load && !bubble && ex_valid && (exmem_rdst == ex_rs);
    assign wb_hit    = memwb_we && ex_valid && (memwb_rdst == ex_rs);
    assign ld_hit[i] = exmem_we && exmem_is_load && !bubble && ex_valid && (exmem_rdst == ex_rs);

    assign op_exs[i*2 +: 2] = !rst   ? 2'b00 :
                              ex_hit ? 2'b10 :
                              wb_hit ? 2'b01 : 2'b00;
    assign op_ids[i] = rst && memwb_we && id_valid && (memwb_rdst == id_rs);
  end

  assign hz = |ld_hit;

  // WAIT ignores EX/MEM entirely; the bubble cycle suppresses detection through ld_hit.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    bubble_next = 1'b0;
    stall_int   = 1'b0;
    count_en    = 1'b0;
    case (state)
      IDLE: begin
        stall_int = hz;
        if (hz) begin
          count_en = 1'b1;
          if (LOAD_LAT > 1) begin
            state_next = WAIT;
            cnt_next   = LAT_M1;
          end else begin
            bubble_next = 1'b1;
          end
        end
      end
      WAIT: begin
        stall_int = 1'b1;
        cnt_next  = cnt - 4'd1;
        if (cnt <= 4'd1) begin
          state_next  = IDLE;
          bubble_next = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 4'd0;
      end
    endcase
  end

  assign stall = rst && stall_int;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      bubble   <= 1'b0;
      hz_count <= 16'd0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      bubble <= bubble_next;
      if (count_en && (hz_count != 16'hFFFF)) begin
        hz_count <= hz_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Random and directed bench for fwd_hazard_unit: three parameterisations share one stimulus
// stream and are compared every cycle against a stall-countdown reference model.
module tb_fwd_hazard_unit;

  logic       clk;
  logic       rst;
  logic [1:0] ifid_need;
  logic [9:0] ifid_rs;
  logic [1:0] idex_need;
  logic [9:0] idex_rs;
  logic       exmem_we;
  logic       exmem_is_load;
  logic [4:0] exmem_rdst;
  logic       memwb_we;
  logic [4:0] memwb_rdst;

  logic [3:0]  exs_w    [3];
  logic [1:0]  ids_w    [3];
  logic        stall_w  [3];
  logic        bubble_w [3];
  logic [15:0] cnt_w    [3];

  int lat [3] = '{3, 1, 4};
  int zr  [3] = '{1, 0, 1};

  int rem [3] = '{0, 0, 0};
  logic mb [3] = '{1'b0, 1'b0, 1'b0};
  int mc [3] = '{0, 0, 0};

  int   n_checks = 0;
  int   n_fail   = 0;
  logic preload_req = 1'b0;

  fwd_hazard_unit #(.RB(5), .NSRC(2), .LOAD_LAT(3), .ZERO_REG(1)) dut_a (
    .clk(clk), .rst(rst), .ifid_need(ifid_need), .ifid_rs(ifid_rs),
    .idex_need(idex_need), .idex_rs(idex_rs), .exmem_we(exmem_we),
    .exmem_is_load(exmem_is_load), .exmem_rdst(exmem_rdst), .memwb_we(memwb_we),
    .memwb_rdst(memwb_rdst), .op_exs(exs_w[0]), .op_ids(ids_w[0]), .stall(stall_w[0]),
    .bubble(bubble_w[0]), .hz_count(cnt_w[0]));

  fwd_hazard_unit #(.RB(5), .NSRC(2), .LOAD_LAT(1), .ZERO_REG(0)) dut_b (
    .clk(clk), .rst(rst), .ifid_need(ifid_need), .ifid_rs(ifid_rs),
    .idex_need(idex_need), .idex_rs(idex_rs), .exmem_we(exmem_we),
    .exmem_is_load(exmem_is_load), .exmem_rdst(exmem_rdst), .memwb_we(memwb_we),
    .memwb_rdst(memwb_rdst), .op_exs(exs_w[1]), .op_ids(ids_w[1]), .stall(stall_w[1]),
    .bubble(bubble_w[1]), .hz_count(cnt_w[1]));

  fwd_hazard_unit #(.RB(5), .NSRC(2), .LOAD_LAT(4), .ZERO_REG(1)) dut_c (
    .clk(clk), .rst(rst), .ifid_need(ifid_need), .ifid_rs(ifid_rs),
    .idex_need(idex_need), .idex_rs(idex_rs), .exmem_we(exmem_we),
    .exmem_is_load(exmem_is_load), .exmem_rdst(exmem_rdst), .memwb_we(memwb_we),
    .memwb_rdst(memwb_rdst), .op_exs(exs_w[2]), .op_ids(ids_w[2]), .stall(stall_w[2]),
    .bubble(bubble_w[2]), .hz_count(cnt_w[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input int k, input logic [31:0] act,
                              input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s dut%0d: got %0h expected %0h", name, k, act, exp);
    end
  endtask

  function automatic logic is_z(input int k, input logic [4:0] r);
    return (zr[k] != 0) && (r == 5'd0);
  endfunction

  // Reference: rem counts stall cycles still owed after the current one.
  task automatic model_eval(input int k, output logic [3:0] e_exs, output logic [1:0] e_ids,
                            output logic e_stall, output logic hz);
    logic [4:0] rs;
    logic [4:0] fs;
    logic       load_any;
    e_exs    = '0;
    e_ids    = '0;
    e_stall  = 1'b0;
    hz       = 1'b0;
    load_any = 1'b0;
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        rs = idex_rs[i*5 +: 5];
        fs = ifid_rs[i*5 +: 5];
        if (idex_need[i] && !is_z(k, rs)) begin
          if (exmem_we && exmem_rdst == rs && !mb[k]) begin
            if (exmem_is_load) load_any = 1'b1;
            else e_exs[i*2 +: 2] = 2'b10;
          end
          if (e_exs[i*2 +: 2] == 2'b00 && memwb_we && memwb_rdst == rs) e_exs[i*2 +: 2] = 2'b01;
        end
        if (ifid_need[i] && !is_z(k, fs) && memwb_we && memwb_rdst == fs) e_ids[i] = 1'b1;
      end
      hz      = load_any && (rem[k] == 0);
      e_stall = hz || (rem[k] > 0);
    end
  endtask

  always @(negedge clk) begin
    logic [3:0] e_exs;
    logic [1:0] e_ids;
    logic       e_stall;
    logic       hz;
    for (int k = 0; k < 3; k++) begin
      model_eval(k, e_exs, e_ids, e_stall, hz);
      check_output("op_exs", k, 32'(exs_w[k]), 32'(e_exs));
      check_output("op_ids", k, 32'(ids_w[k]), 32'(e_ids));
      check_output("stall", k, 32'(stall_w[k]), 32'(e_stall));
      check_output("bubble", k, 32'(bubble_w[k]), 32'(mb[k]));
      check_output("hz_count", k, 32'(cnt_w[k]), 32'(mc[k]));
      if (!rst) begin
        rem[k] = 0;
        mb[k]  = 1'b0;
        mc[k]  = 0;
      end else if (rem[k] > 0) begin
        rem[k] = rem[k] - 1;
        mb[k]  = (rem[k] == 0);
      end else if (hz) begin
        rem[k] = lat[k] - 1;
        mb[k]  = (lat[k] == 1);
        mc[k]  = (mc[k] < 65535) ? mc[k] + 1 : 65535;
      end else begin
        mb[k] = 1'b0;
      end
    end
    if (preload_req) begin
      force dut_a.hz_count = 16'hFFFE;
      release dut_a.hz_count;
      mc[0] = 16'hFFFE;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic r, input logic [1:0] fn, input logic [9:0] frs,
                                input logic [1:0] en, input logic [9:0] ers,
                                input logic xwe, input logic xld, input logic [4:0] xrd,
                                input logic wwe, input logic [4:0] wrd);
    rst           = r;
    ifid_need     = fn;
    ifid_rs       = frs;
    idex_need     = en;
    idex_rs       = ers;
    exmem_we      = xwe;
    exmem_is_load = xld;
    exmem_rdst    = xrd;
    memwb_we      = wwe;
    memwb_rdst    = wrd;
  endtask

  task automatic quiet(input int n);
    for (int j = 0; j < n; j++) begin
      step();
      apply_stimulus(1'b1, 2'b00, 10'd0, 2'b00, 10'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    end
  endtask

  initial begin
    apply_stimulus(1'b0, 2'b00, 10'd0, 2'b00, 10'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    repeat (2) step();
    rst = 1'b1;

    for (int n = 0; n < 3000; n++) begin
      step();
      apply_stimulus(($urandom_range(0, 49) != 0), 2'($urandom), {5'($urandom_range(0, 3)),
                     5'($urandom_range(0, 3))}, 2'($urandom), {5'($urandom_range(0, 3)),
                     5'($urandom_range(0, 3))}, 1'($urandom), 1'($urandom),
                     5'($urandom_range(0, 3)), 1'($urandom), 5'($urandom_range(0, 3)));
    end
    quiet(6);

    // Reset dropped in the second stall cycle of the LOAD_LAT=4 instance.
    step();
    apply_stimulus(1'b1, 2'b00, 10'd0, 2'b10, {5'd9, 5'd0}, 1'b1, 1'b1, 5'd9, 1'b0, 5'd0);
    @(negedge clk);
    check_output("rst_mid_stall_t0", 2, 32'(stall_w[2]), 32'd1);
    step();
    rst = 1'b0;
    @(negedge clk);
    check_output("rst_mid_stall_drop", 2, 32'(stall_w[2]), 32'd0);
    quiet(1);
    @(negedge clk);
    check_output("rst_after_bubble", 2, 32'(bubble_w[2]), 32'd0);
    check_output("rst_after_count", 2, 32'(cnt_w[2]), 32'd0);
    check_output("rst_after_stall", 2, 32'(stall_w[2]), 32'd0);
    quiet(2);

    // ALU chain: EX/MEM beats MEM/WB on operand 0, operand 1 unmatched.
    step();
    apply_stimulus(1'b1, 2'b00, 10'd0, 2'b11, {5'd7, 5'd5}, 1'b1, 1'b0, 5'd5, 1'b1, 5'd5);
    @(negedge clk);
    check_output("alu_chain", 0, 32'(exs_w[0]), 32'h2);

    // Zero register everywhere.
    step();
    apply_stimulus(1'b1, 2'b11, 10'd0, 2'b11, 10'd0, 1'b1, 1'b0, 5'd0, 1'b1, 5'd0);
    @(negedge clk);
    check_output("zero_exs", 0, 32'(exs_w[0]), 32'h0);
    check_output("zero_ids", 0, 32'(ids_w[0]), 32'h0);
    check_output("zero_off_exs", 1, 32'(exs_w[1]), 32'hA);
    step();
    exmem_is_load = 1'b1;
    @(negedge clk);
    check_output("zero_stall", 0, 32'(stall_w[0]), 32'd0);
    check_output("zero_off_stall", 1, 32'(stall_w[1]), 32'd1);
    quiet(3);
    @(negedge clk);
    check_output("zero_count", 0, 32'(cnt_w[0]), 32'd0);
    check_output("zero_off_count", 1, 32'(cnt_w[1]), 32'd1);

    // Load-use on operand 1.
    step();
    apply_stimulus(1'b1, 2'b00, 10'd0, 2'b10, {5'd9, 5'd0}, 1'b1, 1'b1, 5'd9, 1'b0, 5'd0);
    @(negedge clk);
    check_output("ld3_stall_t0", 0, 32'(stall_w[0]), 32'd1);
    check_output("ld1_stall_t0", 1, 32'(stall_w[1]), 32'd1);
    step();
    @(negedge clk);
    check_output("ld3_stall_t1", 0, 32'(stall_w[0]), 32'd1);
    check_output("ld1_bubble_t1", 1, 32'(bubble_w[1]), 32'd1);
    check_output("ld1_stall_t1", 1, 32'(stall_w[1]), 32'd0);
    check_output("ld1_exs_t1", 1, 32'(exs_w[1]), 32'h0);
    step();
    @(negedge clk);
    check_output("ld3_stall_t2", 0, 32'(stall_w[0]), 32'd1);
    step();
    memwb_we   = 1'b1;
    memwb_rdst = 5'd9;
    @(negedge clk);
    check_output("ld3_bubble_t3", 0, 32'(bubble_w[0]), 32'd1);
    check_output("ld3_stall_t3", 0, 32'(stall_w[0]), 32'd0);
    check_output("ld3_exs_t3", 0, 32'(exs_w[0]), 32'h4);
    check_output("ld3_count", 0, 32'(cnt_w[0]), 32'd1);
    quiet(6);

    // Decode forwarding from MEM/WB.
    step();
    apply_stimulus(1'b1, 2'b11, {5'd3, 5'd12}, 2'b01, {5'd0, 5'd3}, 1'b0, 1'b0, 5'd0, 1'b1, 5'd12);
    @(negedge clk);
    check_output("dec_ids", 0, 32'(ids_w[0]), 32'h1);

    // Counter saturation from a preloaded value.
    quiet(1);
    preload_req = 1'b1;
    step();
    preload_req = 1'b0;
    apply_stimulus(1'b1, 2'b00, 10'd0, 2'b10, {5'd9, 5'd0}, 1'b1, 1'b1, 5'd9, 1'b0, 5'd0);
    repeat (6) step();
    @(negedge clk);
    check_output("sat_count", 0, 32'(cnt_w[0]), 32'hFFFF);
    quiet(6);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
